// File: rtl/message_scheduler_pkg.sv
// Shared comm package: message header codes, payload field layout and scheduler types.
// Used by the scheduler, the sender and the receiver.
package message_scheduler_pkg;

  localparam int unsigned HDR_W     = 3;
  localparam int unsigned PAYLOAD_W = 21;
  localparam int unsigned MSG_W     = HDR_W + PAYLOAD_W;
  localparam int unsigned NUM_REQ   = 6;

  // Ball payload bit fields
  localparam int unsigned BALL_Y_LSB = 12;
  localparam int unsigned BALL_Y_W   = 9;
  localparam int unsigned VEL_X_LSB  = 8;
  localparam int unsigned VEL_X_W    = 4;
  localparam int unsigned VEL_Y_LSB  = 4;
  localparam int unsigned VEL_Y_W    = 4;
  localparam int unsigned SIGN_Y_BIT = 3;

  // Pending-vector bit positions
  localparam int unsigned IDX_R_U_THERE  = 0;
  localparam int unsigned IDX_I_AM_HERE  = 1;
  localparam int unsigned IDX_START_GAME = 2;
  localparam int unsigned IDX_BALL       = 3;
  localparam int unsigned IDX_MISSED     = 4;
  localparam int unsigned IDX_LOST       = 5;

  typedef enum logic [HDR_W-1:0] {
    HDR_NONE       = 3'b000,
    HDR_R_U_THERE  = 3'b001,
    HDR_I_AM_HERE  = 3'b010,
    HDR_START_GAME = 3'b011,
    HDR_BALL       = 3'b100,
    HDR_MISSED     = 3'b101,
    HDR_LOST       = 3'b110
  } header_t;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [BALL_Y_W-1:0] ball_y;
    logic [VEL_X_W-1:0]  vel_x;
    logic [VEL_Y_W-1:0]  vel_y;
    logic                sign_y;
  } ball_payload_t;

  function automatic logic [PAYLOAD_W-1:0] pack_ball(input ball_payload_t b);
    return {b.ball_y, b.vel_x, b.vel_y, b.sign_y, 3'b000};
  endfunction

endpackage

// File: rtl/message_scheduler_if.sv
// Request/launch bus between game logic, the scheduler and the message sender.
interface message_scheduler_if;
  import message_scheduler_pkg::*;

  logic                req_r_u_there;
  logic                req_i_am_here;
  logic                req_start_game;
  logic                req_missed;
  logic                req_lost;
  logic                req_ball;
  logic [BALL_Y_W-1:0] ball_y;
  logic [VEL_X_W-1:0]  vel_x;
  logic [VEL_Y_W-1:0]  vel_y;
  logic                sign_y;
  logic                start_ack;
  logic                message_sent;
  logic                send_new_message;
  logic [MSG_W-1:0]    msg;
  logic                busy;
  logic                link_fail;

  modport master (
    output req_r_u_there, req_i_am_here, req_start_game, req_missed, req_lost,
           req_ball, ball_y, vel_x, vel_y, sign_y, start_ack, message_sent,
    input  send_new_message, msg, busy, link_fail
  );

  modport slave (
    input  req_r_u_there, req_i_am_here, req_start_game, req_missed, req_lost,
           req_ball, ball_y, vel_x, vel_y, sign_y, start_ack, message_sent,
    output send_new_message, msg, busy, link_fail
  );

endinterface

// File: rtl/message_scheduler_priority_encoder.sv
// Fixed-priority select over pending requests: lost > missed > start_game >
// i_am_here > r_u_there > ball.
module msg_priority_encoder
  import message_scheduler_pkg::*;
(
  input  logic [NUM_REQ-1:0] pending,
  output logic [NUM_REQ-1:0] grant_c,
  output header_t            header_c
);

  always_comb begin
    grant_c  = '0;
    header_c = HDR_NONE;
    if (pending[IDX_LOST]) begin
      grant_c[IDX_LOST] = 1'b1;
      header_c          = HDR_LOST;
    end else if (pending[IDX_MISSED]) begin
      grant_c[IDX_MISSED] = 1'b1;
      header_c            = HDR_MISSED;
    end else if (pending[IDX_START_GAME]) begin
      grant_c[IDX_START_GAME] = 1'b1;
      header_c                = HDR_START_GAME;
    end else if (pending[IDX_I_AM_HERE]) begin
      grant_c[IDX_I_AM_HERE] = 1'b1;
      header_c               = HDR_I_AM_HERE;
    end else if (pending[IDX_R_U_THERE]) begin
      grant_c[IDX_R_U_THERE] = 1'b1;
      header_c               = HDR_R_U_THERE;
    end else if (pending[IDX_BALL]) begin
      grant_c[IDX_BALL] = 1'b1;
      header_c          = HDR_BALL;
    end
  end

endmodule

// File: rtl/message_scheduler.sv
// Queues one-cycle message requests, launches them to the sender in priority
// order, and retransmits start_game until acknowledged or retries run out.
module message_scheduler
  import message_scheduler_pkg::*;
#(
  parameter int unsigned RETRY_CYCLES = 1_000_000,
  parameter int unsigned MAX_RETRIES  = 8
) (
  input logic               clock,
  input logic               reset,
  message_scheduler_if.slave bus
);

  localparam int unsigned TMR_W  = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
  localparam int unsigned RCNT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  pending_q, pending_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  ball_payload_t       ball_q, ball_d;
  logic [MSG_W-1:0]    msg_q, msg_d;
  logic                snm_q, snm_d;
  logic                busy_q, busy_d;
  logic                link_fail_q, link_fail_d;
  logic                ack_out_q, ack_out_d;
  logic                tmr_run_q, tmr_run_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [RCNT_W-1:0]   retry_cnt_q, retry_cnt_d;

  logic [NUM_REQ-1:0]  req_vec;
  logic [NUM_REQ-1:0]  enc_grant;
  header_t             enc_header;

  always_comb begin
    req_vec                 = '0;
    req_vec[IDX_R_U_THERE]  = bus.req_r_u_there;
    req_vec[IDX_I_AM_HERE]  = bus.req_i_am_here;
    req_vec[IDX_START_GAME] = bus.req_start_game;
    req_vec[IDX_BALL]       = bus.req_ball;
    req_vec[IDX_MISSED]     = bus.req_missed;
    req_vec[IDX_LOST]       = bus.req_lost;
  end

  msg_priority_encoder u_prio (
    .pending  (pending_q),
    .grant_c  (enc_grant),
    .header_c (enc_header)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if ((|pending_q) && bus.message_sent) state_d = S_LAUNCH;
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!bus.message_sent) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.message_sent) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Pending flags, message capture and start_game retry bookkeeping.
  always_comb begin
    pending_d   = pending_q;
    grant_d     = grant_q;
    ball_d      = ball_q;
    msg_d       = msg_q;
    ack_out_d   = ack_out_q;
    tmr_run_d   = tmr_run_q;
    tmr_d       = tmr_q;
    retry_cnt_d = retry_cnt_q;
    link_fail_d = link_fail_q;

    if (state_q == S_IDLE && state_d == S_LAUNCH) begin
      grant_d = enc_grant;
      msg_d   = {enc_header, enc_grant[IDX_BALL] ? pack_ball(ball_q) : PAYLOAD_W'(0)};
    end

    if (state_q == S_LAUNCH) pending_d = pending_d & ~grant_q;

    if (state_q == S_LAUNCH && grant_q[IDX_START_GAME]) begin
      ack_out_d = 1'b1;
      tmr_run_d = 1'b1;
      tmr_d     = TMR_W'(RETRY_CYCLES - 1);
    end else if (tmr_run_q) begin
      if (tmr_q == '0) begin
        tmr_run_d = 1'b0;
        if (retry_cnt_q < RCNT_W'(MAX_RETRIES)) begin
          pending_d[IDX_START_GAME] = 1'b1;
          retry_cnt_d               = retry_cnt_q + RCNT_W'(1);
        end else begin
          link_fail_d = 1'b1;
          ack_out_d   = 1'b0;
        end
      end else begin
        tmr_d = tmr_q - TMR_W'(1);
      end
    end

    if (bus.start_ack && ack_out_q) begin
      ack_out_d                 = 1'b0;
      tmr_run_d                 = 1'b0;
      tmr_d                     = '0;
      retry_cnt_d               = '0;
      pending_d[IDX_START_GAME] = 1'b0;
    end

    // A fresh start_game request restarts the retry sequence from zero.
    if (bus.req_start_game) begin
      tmr_run_d   = 1'b0;
      tmr_d       = '0;
      retry_cnt_d = '0;
    end

    // New requests win over clears in the same cycle.
    pending_d = pending_d | req_vec;
    if (bus.req_ball) begin
      ball_d.ball_y = bus.ball_y;
      ball_d.vel_x  = bus.vel_x;
      ball_d.vel_y  = bus.vel_y;
      ball_d.sign_y = bus.sign_y;
    end

    snm_d  = (state_d == S_LAUNCH);
    busy_d = (|pending_d) || (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q   <= '0;
      grant_q     <= '0;
      ball_q      <= '0;
      msg_q       <= '0;
      snm_q       <= 1'b0;
      busy_q      <= 1'b0;
      link_fail_q <= 1'b0;
      ack_out_q   <= 1'b0;
      tmr_run_q   <= 1'b0;
      tmr_q       <= '0;
      retry_cnt_q <= '0;
    end else begin
      pending_q   <= pending_d;
      grant_q     <= grant_d;
      ball_q      <= ball_d;
      msg_q       <= msg_d;
      snm_q       <= snm_d;
      busy_q      <= busy_d;
      link_fail_q <= link_fail_d;
      ack_out_q   <= ack_out_d;
      tmr_run_q   <= tmr_run_d;
      tmr_q       <= tmr_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign bus.send_new_message = snm_q;
  assign bus.msg              = msg_q;
  assign bus.busy             = busy_q;
  assign bus.link_fail        = link_fail_q;

endmodule

// File: doc/message_scheduler.md
MESSAGE_SCHEDULER -- requirements
Module: message_scheduler

Interface
REQ-001 Parameter RETRY_CYCLES, default 1_000_000: cycles between start_game retransmissions while an ack is outstanding.
REQ-002 Parameter MAX_RETRIES, default 8: retransmissions allowed before declaring link failure.
REQ-003 clock  input  1  single system clock; all logic on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_r_u_there, req_i_am_here, req_start_game, req_missed, req_lost  input  1 each  one-cycle request pulses from game logic.
REQ-006 req_ball  input  1  one-cycle request; samples ball_y[8:0], vel_x[3:0], vel_y[3:0], sign_y in the same cycle.
REQ-007 start_ack  input  1  one-cycle pulse: peer acknowledged start_game.
REQ-008 message_sent  input  1  level; sender is idle and ready for a new message.
REQ-009 send_new_message  output  1  one-cycle launch strobe to the sender.
REQ-010 msg  output  24  {header[2:0], payload[20:0]}; stable from the launch cycle until message_sent next rises.
REQ-011 busy  output  1  high whenever any request is pending or a send is in flight.
REQ-012 link_fail  output  1  sticky; set when start_game retries are exhausted.

Function
REQ-013 Each request sets a pending flag; ball payload is latched on req_ball, and a later req_ball overwrites the latched payload (newest wins).
REQ-014 Fixed priority, highest first: lost(110), missed(101), start_game(011), i_am_here(010), r_u_there(001), ball(100).
REQ-015 Ball payload: [20:12]=ball_y, [11:8]=vel_x, [7:4]=vel_y, [3]=sign_y, [2:0]=0; all other messages have payload 0.
REQ-016 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE -> LAUNCH when any flag is pending and message_sent=1; winner is selected and msg registered on that edge.
REQ-018 LAUNCH: send_new_message=1 for exactly one cycle; the winner's flag clears; -> WAIT_BUSY.
REQ-019 WAIT_BUSY -> WAIT_DONE when message_sent=0; WAIT_DONE -> IDLE when message_sent=1.
REQ-020 Minimum spacing between launches is 4 cycles; back-to-back pending messages are sent in priority order.
REQ-021 A request arriving in the same cycle its flag clears leaves the flag set (set beats clear); the new payload applies to a ball request.
REQ-022 After start_game launches, the retry counter loads RETRY_CYCLES-1 and decrements each cycle; at 0 with no ack it re-sets the start_game flag and increments retry_count.
REQ-023 start_ack clears the outstanding-ack state, the retry counter, retry_count and any pending start_game flag; start_ack with nothing outstanding is ignored.
REQ-024 When retry_count reaches MAX_RETRIES, no further retries occur and link_fail=1 until reset.
REQ-025 A new req_start_game restarts the retry sequence with retry_count=0 and does not clear link_fail.
REQ-026 msg is unchanged outside IDLE->LAUNCH transitions.

Reset
REQ-027 On reset: state=IDLE, all pending flags=0, latched payload=0, msg=0, send_new_message=0, busy=0, link_fail=0, retry counter and retry_count=0.
REQ-028 Reset asserted mid-send abandons the message, with no further strobe; requests in the reset cycle are dropped.

Structure
REQ-029 header_t enum (codes in REQ-014) and the payload bit-field constants belong in a shared comm package used by the sender and the receiver.
REQ-030 The priority select is a sub-module, msg_priority_encoder (pending vector in, one-hot grant plus header out).

Verification
REQ-031 req_ball (y=0x1A5, vx=3, vy=7, sign=1), message_sent=1 -> strobe 2 cycles later, msg=0x9A5378.
REQ-032 req_lost, req_missed and req_ball in the same cycle -> launches in order: header 110, then 101, then 100, each launch after the message_sent low->high cycle.
REQ-033 req_start_game, no ack, RETRY_CYCLES=16, MAX_RETRIES=2 -> 3 start_game launches, then link_fail=1, then no further launches.
REQ-034 start_ack 5 cycles after the first start_game launch -> no retransmission within 100 cycles; busy=0.
REQ-035 req_ball twice (y=10, then y=20) while message_sent=0 -> a single ball launch carrying y=20.
REQ-036 reset in WAIT_BUSY with r_u_there pending -> all outputs 0 the next cycle; no launch after message_sent returns.
